// File: rtl/tape_loader_if.sv
// Bus bundle between the host/player side and tape_loader.
// The master modport is the host/player and the slave modport is the loader.
interface tape_loader_if #(
    parameter int AW = 16
);
    logic          dl_en;
    logic          dl_wr;
    logic [7:0]    dl_d;
    logic [AW-1:0] ra;
    logic [7:0]    rq;
    logic [AW-1:0] size;
    logic          ready;
    logic          done;
    logic          error;
    logic          overflow;

    modport master (
        output dl_en, dl_wr, dl_d, ra,
        input  rq, size, ready, done, error, overflow
    );

    modport slave (
        input  dl_en, dl_wr, dl_d, ra,
        output rq, size, ready, done, error, overflow
    );
endinterface

// File: rtl/tape_loader.sv
// tape_loader: captures a streamed tape image into a 2^AW byte RAM and reports
// whether the image is usable by the player.
// Optional build macro TAPE_SIGNATURE_CHECK_EN: require the first eight bytes to
// be "ZXTape!" followed by 0x1A. The signature check needs AW >= 4.
// The last RAM location (2^AW-1) is never written; a full image holds 2^AW-1 bytes.
module tape_loader #(
    parameter int AW = 16
) (
    input  logic          clock,
    input  logic          reset,
    tape_loader_if.slave  bus
);
    localparam logic [AW-1:0] WP_MAX  = {AW{1'b1}};
    localparam logic [AW-1:0] WP_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] WP_ONE  = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          dl_en_q;
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] size_q, size_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    rq_q;
    logic          rise_s, fall_s, we_s, fail_s;
    logic [7:0]    mem [0:(2**AW)-1];

`ifdef TAPE_SIGNATURE_CHECK_EN
    logic          sig_bad_q, sig_bad_d;

    // Expected header byte for image position idx.
    function automatic logic [7:0] sig_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h5A; // Z
            3'd1:    b = 8'h58; // X
            3'd2:    b = 8'h54; // T
            3'd3:    b = 8'h61; // a
            3'd4:    b = 8'h70; // p
            3'd5:    b = 8'h65; // e
            3'd6:    b = 8'h21; // !
            3'd7:    b = 8'h1A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction
`endif

    // Next-state logic: edge detection on dl_en, byte capture and the READY/ERROR verdict.
    always_comb begin
        rise_s  = bus.dl_en & ~dl_en_q;
        fall_s  = ~bus.dl_en & dl_en_q;
        state_d = state_q;
        wp_d    = wp_q;
        size_d  = size_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        error_d = error_q;
        ovf_d   = ovf_q;
        we_s    = 1'b0;
        fail_s  = 1'b0;
`ifdef TAPE_SIGNATURE_CHECK_EN
        sig_bad_d = sig_bad_q;
`endif
        if (rise_s) begin
            state_d = LOAD;
            wp_d    = WP_ZERO;
            size_d  = WP_ZERO;
            ready_d = 1'b0;
            error_d = 1'b0;
            ovf_d   = 1'b0;
`ifdef TAPE_SIGNATURE_CHECK_EN
            sig_bad_d = 1'b0;
`endif
        end else begin
            case (state_q)
                LOAD: begin
                    // dl_en_q is high throughout LOAD, so a byte strobed in the
                    // cycle dl_en is first seen low is still captured here.
                    if (bus.dl_wr) begin
                        if (wp_q != WP_MAX) begin
                            we_s = 1'b1;
                            wp_d = wp_q + WP_ONE;
`ifdef TAPE_SIGNATURE_CHECK_EN
                            if ((wp_q < AW'(8)) && (bus.dl_d != sig_byte(wp_q[2:0]))) begin
                                sig_bad_d = 1'b1;
                            end else begin
                                sig_bad_d = sig_bad_q;
                            end
`endif
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        wp_d = wp_q;
                    end
                    if (fall_s) begin
                        fail_s = (wp_d == WP_ZERO) | ovf_d;
`ifdef TAPE_SIGNATURE_CHECK_EN
                        fail_s = fail_s | sig_bad_d | (wp_d < AW'(8));
`endif
                        if (fail_s) begin
                            state_d = ERROR;
                            error_d = 1'b1;
                            ready_d = 1'b0;
                            size_d  = WP_ZERO;
                        end else begin
                            state_d = READY;
                            ready_d = 1'b1;
                            done_d  = 1'b1;
                            size_d  = wp_d;
                        end
                    end else begin
                        state_d = LOAD;
                    end
                end
                IDLE:    state_d = IDLE;
                READY:   state_d = READY;
                ERROR:   state_d = ERROR;
                default: state_d = IDLE;
            endcase
        end
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dl_en_q <= 1'b0;
            wp_q    <= WP_ZERO;
            size_q  <= WP_ZERO;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef TAPE_SIGNATURE_CHECK_EN
            sig_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dl_en_q <= bus.dl_en;
            wp_q    <= wp_d;
            size_q  <= size_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            error_q <= error_d;
            ovf_q   <= ovf_d;
`ifdef TAPE_SIGNATURE_CHECK_EN
            sig_bad_q <= sig_bad_d;
`endif
        end
    end

    // Loader write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (we_s) begin
            mem[wp_q] <= bus.dl_d;
        end
    end

    // Player read port with one cycle of latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rq_q <= 8'h00;
        end else begin
            rq_q <= mem[bus.ra];
        end
    end

    assign bus.rq       = rq_q;
    assign bus.size     = size_q;
    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_tape_loader.sv
// Scoreboard bench for tape_loader (AW=5, 31-byte capacity).
module tb_tape_loader;
    localparam int AW  = 5;
    localparam int CAP = (1 << AW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tape_loader_if #(.AW(AW)) bus ();
    tape_loader #(.AW(AW)) dut (.clock(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        bit ready;
        bit error;
        bit ovf;
        int size;
    } outcome_t;

    outcome_t   exp_q[$];
    int         rd_q[$];
    logic       rd_vld   = 1'b0;
    logic       rd_vld_d = 1'b0;
    int         n_chk    = 0;
    int         n_pass   = 0;
    logic [7:0] tx    [0:63];
    logic [7:0] mem_m [0:CAP];

    always @(posedge clk) rd_vld_d <= rd_vld;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic void set_sig();
        logic [63:0] s;
        s = {"ZXTape!", 8'h1A};
        for (int i = 0; i < 8; i++) tx[i] = s[63-8*i -: 8];
    endfunction

    function automatic void fill_rand(input int n);
        for (int i = 0; i < n; i++) tx[i] = 8'($urandom_range(0, 255));
    endfunction

    // Reference: outcome of an n-byte image, recording the bytes the RAM keeps.
    function automatic outcome_t predict(input int n);
        outcome_t e;
        int stored;
        bit ok;
        logic [63:0] s;
        s = {"ZXTape!", 8'h1A};
        stored = (n > CAP) ? CAP : n;
        e.ovf  = (n > CAP);
        ok     = (stored > 0) && !e.ovf;
`ifdef TAPE_SIGNATURE_CHECK_EN
        if (stored < 8) ok = 1'b0;
        for (int i = 0; i < 8 && i < stored; i++)
            if (tx[i] != s[63-8*i -: 8]) ok = 1'b0;
`endif
        e.ready = ok;
        e.error = !ok;
        e.size  = ok ? stored : 0;
        for (int i = 0; i < stored; i++) mem_m[i] = tx[i];
        return e;
    endfunction

    task automatic download(input int n, input bit coinc, input bit gaps, output outcome_t e);
        e = predict(n);
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.dl_en = 1'b1;
        bus.dl_wr = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    bus.dl_wr = 1'b0;
                end
            end
            @(posedge clk); #1;
            bus.dl_wr = 1'b1;
            bus.dl_d  = tx[i];
            if (coinc && (i == n - 1)) bus.dl_en = 1'b0;
        end
        @(posedge clk); #1;
        bus.dl_wr = 1'b0;
        bus.dl_en = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic rd(input int a);
        @(posedge clk); #1;
        bus.ra = a[AW-1:0];
        rd_vld = 1'b1;
        rd_q.push_back(int'(mem_m[a]));
        @(posedge clk); #1;
        rd_vld = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports an outcome or read data.
    initial begin
        bit prev_err;
        bit chk_low;
        outcome_t e;
        prev_err = 1'b0;
        chk_low  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_err = 1'b0;
                chk_low  = 1'b0;
            end else begin
                if (chk_low) begin
                    chk("done_one_cycle", int'(bus.done), 0);
                    chk_low = 1'b0;
                end
                if (bus.done || (bus.error && !prev_err)) begin
                    chk("outcome_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("ready", int'(bus.ready), int'(e.ready));
                        chk("error", int'(bus.error), int'(e.error));
                        chk("overflow", int'(bus.overflow), int'(e.ovf));
                        chk("size", int'(bus.size), e.size);
                        chk("done_pulse", int'(bus.done), int'(e.ready));
                    end
                    if (bus.done) chk_low = 1'b1;
                end
                prev_err = bus.error;
                if (rd_vld_d) begin
                    chk("read_expected", int'(rd_q.size() > 0), 1);
                    if (rd_q.size() > 0) chk("rq", int'(bus.rq), rd_q.pop_front());
                end
            end
        end
    end

    initial begin
        outcome_t e;
        int n, stored;
        bus.dl_en = 1'b0;
        bus.dl_wr = 1'b0;
        bus.dl_d  = 8'h00;
        bus.ra    = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(bus.ready), 0);
        chk("rst_error", int'(bus.error), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_size", int'(bus.size), 0);
        chk("rst_rq", int'(bus.rq), 0);
        rst = 1'b0;

        // 20 bytes 0x00..0x13, then read back.
        for (int i = 0; i < 20; i++) tx[i] = 8'(i);
        download(20, 1'b0, 1'b0, e);
        rd(5); rd(19); rd(0);

        // Signature image, then the same image with byte 3 corrupted.
        set_sig(); tx[8] = 8'h01; tx[9] = 8'h14;
        download(10, 1'b0, 1'b0, e);
        rd(9);
        tx[3] = 8'h00;
        download(10, 1'b0, 1'b0, e);

        // Capacity boundary: exactly full, then one and two bytes too many.
        fill_rand(CAP); set_sig();
        download(CAP, 1'b0, 1'b0, e);
        rd(CAP - 1); rd(14);
        for (int k = 1; k <= 2; k++) begin
            fill_rand(CAP + k); set_sig();
            download(CAP + k, 1'b0, 1'b0, e);
            rd(CAP - 1); rd(0);
        end

        // Empty download, then stray strobes outside a download window.
        download(0, 1'b0, 1'b0, e);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.dl_wr = 1'b1;
            bus.dl_d  = 8'hEE;
            @(posedge clk); #1;
            bus.dl_wr = 1'b0;
        end
        @(negedge clk);
        chk("stray_error_held", int'(bus.error), 1);
        chk("stray_ready_low", int'(bus.ready), 0);
        rd(0); rd(1);

        // Last byte strobed in the cycle dl_en falls.
        fill_rand(12); set_sig();
        download(12, 1'b1, 1'b0, e);
        rd(11);

        // Reset mid-download with dl_en held high across release.
        fill_rand(5);
        @(posedge clk); #1;
        bus.dl_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.dl_wr = 1'b1;
            bus.dl_d  = tx[i];
            mem_m[i]  = tx[i];
        end
        @(posedge clk); #1;
        bus.dl_wr = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_ready", int'(bus.ready), 0);
        chk("midrst_error", int'(bus.error), 0);
        chk("midrst_overflow", int'(bus.overflow), 0);
        chk("midrst_size", int'(bus.size), 0);
        rst = 1'b0;
        fill_rand(3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.dl_wr = 1'b1;
            bus.dl_d  = tx[i];
        end
        exp_q.push_back(predict(3));
        @(posedge clk); #1;
        bus.dl_wr = 1'b0;
        bus.dl_en = 1'b0;
        repeat (3) @(posedge clk);
        rd(0); rd(2); rd(4);

        // Randomized downloads.
        repeat (10) begin
            n = $urandom_range(0, CAP + 4);
            fill_rand(n);
            if ($urandom_range(0, 3) != 0 && n >= 8) set_sig();
            download(n, 1'($urandom_range(0, 1)), 1'b1, e);
            stored = (n > CAP) ? CAP : n;
            if (stored > 0) begin
                repeat (3) rd($urandom_range(0, stored - 1));
            end
        end

        // Drain scoreboard with a bounded wait.
        for (int t = 0; t < 50 && (exp_q.size() + rd_q.size()) > 0; t++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size() + rd_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
